hnsn_train_sequencer: RTL and testbench

- Programmable phase scheduler that drives hnsn_top's ext_spike_in and reward inputs.
- Replaces hand-written learn/rest/recall stimulus loops with a table of phases. Each phase is a drive window of pattern+reward, followed by a silent rest window.
- Watches char_out/char_changed and reports the last character seen in each phase.
- Sits between the host/config logic and hnsn_top.

---
 rtl/hnsn_seq_pkg.sv | 25 ++
 rtl/hnsn_train_sequencer_if.sv | 49 ++++
 rtl/hnsn_seq_table.sv | 27 ++
 rtl/hnsn_train_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_hnsn_train_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hnsn_seq_pkg.sv
// Shared state encoding, phase-table entry type and default sizes for the training sequencer.
package hnsn_seq_pkg;

    localparam int unsigned SEQ_MAX_PHASES = 8;
    localparam int unsigned SEQ_LEN_W      = 8;
    localparam int unsigned SEQ_N_IN       = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StRest,
        StNext,
        StDone
    } seq_state_e;

    // expect_char: 'expect' is a reserved word, hence the suffix
    typedef struct packed {
        logic [SEQ_N_IN-1:0]  pattern;
        logic                 reward;
        logic [SEQ_LEN_W-1:0] len;
        logic [SEQ_LEN_W-1:0] rest;
        logic [7:0]           expect_char;
    } phase_entry_t;

endpackage

// File: rtl/hnsn_train_sequencer_if.sv
// Sequencer bus: host control/config, hnsn_top stimulus and character feedback, result reporting.
interface hnsn_train_sequencer_if
    import hnsn_seq_pkg::*;
#(
    parameter int unsigned MAX_PHASES = SEQ_MAX_PHASES,
    parameter int unsigned LEN_W      = SEQ_LEN_W,
    parameter int unsigned N_IN       = SEQ_N_IN
);
    localparam int unsigned AW = $clog2(MAX_PHASES);

    logic            start;
    logic            abort;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [N_IN-1:0] cfg_pattern;
    logic            cfg_reward;
    logic [LEN_W-1:0] cfg_len;
    logic [LEN_W-1:0] cfg_rest;
    logic [7:0]      cfg_expect;
    logic [AW-1:0]   last_phase;
    logic [3:0]      loop_count;
    logic [7:0]      char_in;
    logic            char_changed_in;
    logic [N_IN-1:0] ext_spike_out;
    logic            reward_out;
    logic            busy;
    logic            in_rest;
    logic [AW-1:0]   phase_idx;
    logic            done;
    logic            result_valid;
    logic [AW-1:0]   result_phase;
    logic [7:0]      result_char;
    logic [7:0]      mismatch_cnt;

    modport master (
        output start, abort, cfg_we, cfg_addr, cfg_pattern, cfg_reward, cfg_len, cfg_rest,
               cfg_expect, last_phase, loop_count, char_in, char_changed_in,
        input  ext_spike_out, reward_out, busy, in_rest, phase_idx, done, result_valid,
               result_phase, result_char, mismatch_cnt
    );

    modport slave (
        input  start, abort, cfg_we, cfg_addr, cfg_pattern, cfg_reward, cfg_len, cfg_rest,
               cfg_expect, last_phase, loop_count, char_in, char_changed_in,
        output ext_spike_out, reward_out, busy, in_rest, phase_idx, done, result_valid,
               result_phase, result_char, mismatch_cnt
    );

endinterface

// File: rtl/hnsn_seq_table.sv
// Phase table: register array with one synchronous write port and one combinational read port.
module hnsn_seq_table
    import hnsn_seq_pkg::*;
#(
    parameter int unsigned MAX_PHASES = SEQ_MAX_PHASES,
    localparam int unsigned AW = $clog2(MAX_PHASES)
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  phase_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output phase_entry_t rdata_o
);

    // Contents are deliberately not reset so a table survives a run-time reset.
    phase_entry_t mem_q [MAX_PHASES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hnsn_train_sequencer.sv
// Phase scheduler driving hnsn_top stimulus; reports the last character seen in each phase.
// Define HNSN_SEQ_CHECK_EN to store per-phase expected characters and count mismatches.
module hnsn_train_sequencer
    import hnsn_seq_pkg::*;
#(
    parameter int unsigned MAX_PHASES = SEQ_MAX_PHASES,
    parameter int unsigned LEN_W      = SEQ_LEN_W,
    parameter int unsigned N_IN       = SEQ_N_IN
) (
    input logic                   clk,
    input logic                   rst,
    hnsn_train_sequencer_if.slave bus
);

    localparam int unsigned AW = $clog2(MAX_PHASES);
    localparam logic [N_IN-1:0] NoSpike = '0;

    seq_state_e       state_q, state_d;
    logic [AW-1:0]    phase_q, phase_d;
    logic [AW-1:0]    last_q, last_d;
    logic [3:0]       passes_q, passes_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    phase_entry_t     cur_q, cur_d;
    logic [7:0]       cap_q, cap_d;
    logic [7:0]       res_char_q, res_char_d;
    logic [7:0]       cap_nxt;
    logic             enter;
    logic [AW-1:0]    rd_idx;
    phase_entry_t     rd_entry;
    phase_entry_t     wr_entry;

    // The read port always points at the phase about to be entered (0 from IDLE or on wrap).
    assign rd_idx = (state_q == StNext && phase_q < last_q) ? phase_q + 1'b1 : '0;

    always_comb begin
        wr_entry = '{pattern: bus.cfg_pattern, reward: bus.cfg_reward, len: bus.cfg_len,
                     rest: bus.cfg_rest, expect_char: 8'h00};
`ifdef HNSN_SEQ_CHECK_EN
        wr_entry.expect_char = bus.cfg_expect;
`endif
    end

    hnsn_seq_table #(
        .MAX_PHASES (MAX_PHASES)
    ) u_table (
        .clk     (clk),
        .we_i    (bus.cfg_we && state_q == StIdle),
        .waddr_i (bus.cfg_addr),
        .wdata_i (wr_entry),
        .raddr_i (rd_idx),
        .rdata_o (rd_entry)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        last_d     = last_q;
        passes_d   = passes_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        res_char_d = res_char_q;
        enter      = 1'b0;
        cap_nxt    = cap_q;
        if ((state_q == StDrive || state_q == StRest) && bus.char_changed_in) begin
            cap_nxt = bus.char_in;
        end
        cap_d = cap_nxt;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    last_d   = bus.last_phase;
                    passes_d = bus.loop_count;
                    phase_d  = '0;
                    cap_d    = '0;
                    enter    = 1'b1;
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    if (cur_q.rest != '0) begin
                        state_d = StRest;
                        cnt_d   = cur_q.rest - 1'b1;
                    end else begin
                        state_d = StNext;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRest: begin
                if (cnt_q == '0) begin
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StNext: begin
                if (phase_q < last_q) begin
                    phase_d = phase_q + 1'b1;
                    enter   = 1'b1;
                end else if (passes_q != '0) begin
                    passes_d = passes_q - 1'b1;
                    phase_d  = '0;
                    enter    = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                phase_d = '0;
            end
            default: state_d = StIdle;
        endcase

        // Zero-length windows are skipped so a phase may go straight to NEXT.
        if (enter) begin
            cur_d = rd_entry;
            if (rd_entry.len != '0) begin
                state_d = StDrive;
                cnt_d   = rd_entry.len - 1'b1;
            end else if (rd_entry.rest != '0) begin
                state_d = StRest;
                cnt_d   = rd_entry.rest - 1'b1;
            end else begin
                state_d = StNext;
            end
        end

        if (state_d == StNext) begin
            res_char_d = cap_nxt;
            cap_d      = '0;
        end

        if (bus.abort) begin
            state_d    = StIdle;
            phase_d    = '0;
            cnt_d      = '0;
            cap_d      = '0;
            res_char_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            last_q     <= '0;
            passes_q   <= '0;
            cnt_q      <= '0;
            cur_q      <= '0;
            cap_q      <= '0;
            res_char_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            passes_q   <= passes_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            cap_q      <= cap_d;
            res_char_q <= res_char_d;
        end
    end

`ifdef HNSN_SEQ_CHECK_EN
    logic [7:0] mis_q, mis_d;

    // cur_d is the entry of the phase concluding when state_d is NEXT.
    always_comb begin
        mis_d = mis_q;
        if (state_q == StIdle && bus.start && !bus.abort) begin
            mis_d = '0;
        end
        if (state_d == StNext && cur_d.expect_char != 8'h00 &&
            res_char_d != cur_d.expect_char && mis_d != 8'hff) begin
            mis_d = mis_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.mismatch_cnt = mis_q;
`else
    logic unused_expect;
    assign unused_expect    = ^{bus.cfg_expect, cur_q.expect_char};
    assign bus.mismatch_cnt = 8'h00;
`endif

    assign bus.ext_spike_out = (state_q == StDrive) ? cur_q.pattern : NoSpike;
    assign bus.reward_out    = (state_q == StDrive) && cur_q.reward;
    assign bus.busy          = (state_q != StIdle);
    assign bus.in_rest       = (state_q == StRest);
    assign bus.phase_idx     = phase_q;
    assign bus.done          = (state_q == StDone);
    assign bus.result_valid  = (state_q == StNext);
    assign bus.result_phase  = phase_q;
    assign bus.result_char   = res_char_q;

endmodule

// File: tb/tb_hnsn_train_sequencer.sv
// Randomized self-checking bench for hnsn_train_sequencer against a cycle-list reference model.
module tb_hnsn_train_sequencer;

`ifdef HNSN_SEQ_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic clk;
    logic rst;

    hnsn_train_sequencer_if #(.MAX_PHASES(8), .LEN_W(8), .N_IN(4)) bus ();

    hnsn_train_sequencer #(
        .MAX_PHASES (8),
        .LEN_W      (8),
        .N_IN       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] spike;
        logic       reward;
        logic       busy;
        logic       in_rest;
        logic [2:0] phase;
        logic       done;
        logic       rv;
        logic       window;
    } exp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    logic [7:0] inj_map[int];
    logic [7:0] got_chars[$];
    logic [3:0] m_pat[8];
    logic       m_rew[8];
    int         m_len[8];
    int         m_rest[8];
    logic [7:0] m_exp[8];
    int         m_mis;
    int         rl, rloops;
    logic [7:0] want_seq[4] = '{8'h00, 8'h45, 8'h00, 8'h46};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, bus.ext_spike_out, bus.reward_out, bus.busy, bus.in_rest, bus.phase_idx,
                bus.done, bus.result_valid, bus.result_phase, bus.result_char, bus.mismatch_cnt};
    endfunction

    task automatic write_entry(input int a, input logic [3:0] pat, input logic rew, input int len,
                               input int rest, input logic [7:0] ex);
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = 3'(a);
        bus.cfg_pattern = pat;
        bus.cfg_reward  = rew;
        bus.cfg_len     = 8'(len);
        bus.cfg_rest    = 8'(rest);
        bus.cfg_expect  = ex;
        tick();
        bus.cfg_we = 1'b0;
        m_pat[a]  = pat;
        m_rew[a]  = rew;
        m_len[a]  = len;
        m_rest[a] = rest;
        m_exp[a]  = ex;
    endtask

    // Expected per-cycle outputs for cycles 1..N after the start edge.
    task automatic build(input int last, input int loops);
        exp_t e;
        exp_q.delete();
        inj_map.delete();
        for (int l = 0; l <= loops; l++) begin
            for (int p = 0; p <= last; p++) begin
                for (int i = 0; i < m_len[p]; i++) begin
                    e = '0; e.spike = m_pat[p]; e.reward = m_rew[p]; e.busy = 1'b1;
                    e.phase = p[2:0]; e.window = 1'b1;
                    exp_q.push_back(e);
                end
                for (int i = 0; i < m_rest[p]; i++) begin
                    e = '0; e.busy = 1'b1; e.in_rest = 1'b1; e.phase = p[2:0]; e.window = 1'b1;
                    exp_q.push_back(e);
                end
                e = '0; e.busy = 1'b1; e.phase = p[2:0]; e.rv = 1'b1;
                exp_q.push_back(e);
            end
        end
        e = '0; e.busy = 1'b1; e.phase = last[2:0]; e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Decoy at the first window cycle of a phase, the real char at its last window cycle.
    task automatic plan(input int ph, input logic [7:0] ch);
        int first_i = -1;
        int last_i  = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].window && exp_q[i].phase == ph[2:0]) begin
                if (first_i < 0) first_i = i;
                last_i = i;
            end else if (last_i >= 0) begin
                break;
            end
        end
        if (first_i >= 0) inj_map[first_i + 1] = ch ^ 8'h20;
        if (last_i >= 0) inj_map[last_i + 1] = ch;
    endtask

    task automatic run_check(input int last, input int loops);
        logic [7:0] cap;
        int         rv_cnt;
        int         done_cyc;
        int         exp_done;
        exp_t       e;
        cap      = 8'h00;
        rv_cnt   = 0;
        done_cyc = -1;
        m_mis    = 0;
        got_chars.delete();
        bus.last_phase = 3'(last);
        bus.loop_count = 4'(loops);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= exp_q.size(); c++) begin
            e = exp_q[c - 1];
            chk("cycle", {bus.ext_spike_out, bus.reward_out, bus.busy, bus.in_rest, bus.phase_idx,
                          bus.done, bus.result_valid,
                          bus.result_valid ? bus.result_phase : 3'd0},
                {e.spike, e.reward, e.busy, e.in_rest, e.phase, e.done, e.rv,
                 e.rv ? e.phase : 3'd0});
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (bus.result_valid) begin
                rv_cnt++;
                got_chars.push_back(bus.result_char);
            end
            if (e.rv) begin
                chk("result_char", bus.result_char, cap);
                if (CheckEn && m_exp[e.phase] != 8'h00 && cap != m_exp[e.phase] && m_mis < 255)
                    m_mis++;
                cap = 8'h00;
            end
            if (inj_map.exists(c)) begin
                bus.char_changed_in = 1'b1;
                bus.char_in         = inj_map[c];
                if (e.window) cap = inj_map[c];
            end else begin
                bus.char_changed_in = 1'b0;
                bus.char_in         = 8'($urandom);
            end
            if (c == 1) begin
                // Restart and table write while busy must both be ignored.
                bus.start       = 1'b1;
                bus.cfg_we      = 1'b1;
                bus.cfg_addr    = 3'($urandom);
                bus.cfg_pattern = 4'($urandom);
                bus.cfg_len     = 8'($urandom);
                bus.cfg_rest    = 8'($urandom);
                bus.cfg_expect  = 8'($urandom);
            end
            tick();
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
        end
        bus.char_changed_in = 1'b0;
        chk("idle_after", {bus.busy, bus.done, bus.result_valid}, 0);
        exp_done = 0;
        for (int p = 0; p <= last; p++) exp_done += m_len[p] + m_rest[p] + 1;
        exp_done = exp_done * (loops + 1) + 1;
        chk("done_cycle", done_cyc, exp_done);
        chk("rv_count", rv_cnt, (last + 1) * (loops + 1));
        chk("mismatch_cnt", bus.mismatch_cnt, m_mis);
    endtask

    task automatic write_four();
        write_entry(0, 4'b0011, 1'b1, 120, 30, 8'h00);
        write_entry(1, 4'b0001, 1'b0, 100, 30, 8'h45);
        write_entry(2, 4'b1100, 1'b1, 120, 30, 8'h00);
        write_entry(3, 4'b0100, 1'b0, 100, 30, 8'h46);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
        bus.cfg_pattern = '0; bus.cfg_reward = 1'b0; bus.cfg_len = '0; bus.cfg_rest = '0;
        bus.cfg_expect = '0; bus.last_phase = '0; bus.loop_count = '0;
        bus.char_in = '0; bus.char_changed_in = 1'b0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        tick();

        // Single long phase
        write_entry(0, 4'b0011, 1'b1, 120, 30, 8'h00);
        build(0, 0);
        run_check(0, 0);

        // Four phases, chars injected in phases 1 and 3
        write_four();
        build(3, 0);
        plan(1, 8'h45);
        plan(3, 8'h46);
        run_check(3, 0);
        chk("rseq_len", got_chars.size(), 4);
        for (int i = 0; i < 4 && i < got_chars.size(); i++) chk("rseq", got_chars[i], want_seq[i]);
        chk("mis_match_all", bus.mismatch_cnt, 0);
        write_entry(1, 4'b0001, 1'b0, 100, 30, 8'h46);
        build(3, 0);
        plan(1, 8'h45);
        plan(3, 8'h46);
        run_check(3, 0);
        chk("mis_one", bus.mismatch_cnt, CheckEn ? 1 : 0);

        // Zero-length windows
        write_entry(0, 4'b1111, 1'b1, 0, 5, 8'h00);
        write_entry(1, 4'b1010, 1'b1, 0, 0, 8'h41);
        write_entry(2, 4'b0110, 1'b0, 3, 0, 8'h00);
        build(2, 1);
        plan(0, 8'h42);
        run_check(2, 1);

        // Looping two-phase table
        write_entry(0, 4'b0001, 1'b0, 80, 20, 8'h00);
        write_entry(1, 4'b0100, 1'b0, 80, 20, 8'h00);
        build(1, 4);
        run_check(1, 4);

        // Abort mid-DRIVE of phase 1, after phase 0 has logged a mismatch
        write_entry(0, 4'b1001, 1'b1, 2, 0, 8'h5a);
        write_entry(1, 4'b0110, 1'b1, 20, 0, 8'h00);
        bus.last_phase = 3'd1; bus.loop_count = 4'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("abort_pre", {bus.busy, bus.ext_spike_out, bus.phase_idx}, {1'b1, 4'b0110, 3'd1});
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_outputs", {bus.busy, bus.ext_spike_out, bus.reward_out, bus.in_rest,
                              bus.done, bus.result_valid, bus.phase_idx}, 0);
        chk("abort_mis_held", bus.mismatch_cnt, CheckEn ? 1 : 0);
        repeat (4) begin
            tick();
            chk("abort_idle", {bus.busy, bus.done, bus.result_valid}, 0);
        end

        // start together with abort stays idle and keeps mismatch_cnt
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort", bus.busy, 0);
        tick();
        chk("start_abort_2", bus.busy, 0);
        chk("start_abort_mis", bus.mismatch_cnt, CheckEn ? 1 : 0);

        // Asynchronous reset mid-run, then rerun the retained table
        write_four();
        bus.last_phase = 3'd3; bus.loop_count = 4'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1 chk("async_reset", all_outs(), 0);
        #1 rst = 1'b0;
        build(3, 0);
        plan(3, 8'h46);
        run_check(3, 0);

        // Random tables
        for (int r = 0; r < 15; r++) begin
            for (int a = 0; a < 8; a++) begin
                write_entry(a, 4'($urandom), 1'($urandom), $urandom_range(0, 12),
                            $urandom_range(0, 6),
                            ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h41 + $urandom_range(0, 3)));
            end
            rl     = $urandom_range(0, 7);
            rloops = $urandom_range(0, 3);
            build(rl, rloops);
            for (int c = 1; c <= exp_q.size(); c++) begin
                if ($urandom_range(0, 5) == 0) inj_map[c] = 8'(8'h41 + $urandom_range(0, 3));
            end
            run_check(rl, rloops);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
